// File: rtl/clk_div_monitor.sv
// Divided-clock checker: synchronizes a divided clock into the fast domain,
// measures its period and high time, tracks lock against DIV_RATIO and
// reports period, duty and stuck-clock faults.
module clk_div_monitor #(
    parameter int DIV_RATIO   = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear_err,
    input  logic             div_clk_i,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  DIV_C  = CNT_W'(DIV_RATIO);
    localparam logic [CNT_W-1:0]  HALF_C = CNT_W'(DIV_RATIO / 2);
    localparam logic [CNT_W-1:0]  TMO_C  = CNT_W'(2 * DIV_RATIO);
    localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   rise_pulse_q, fall_pulse_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic [GOOD_W-1:0]      good_q, good_d, good_inc;
    logic                   err_q, err_d;
    logic [ERR_W-1:0]       errc_q, errc_d;
    logic                   sync, rise, fall, period_ok;

    assign sync      = sync_q[SYNC_STAGES-1];
    assign rise      = sync & ~prev_q;
    assign fall      = ~sync & prev_q;
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], div_clk_i};
    // high_q is always from the fall inside the period just ended; a fall and a
    // rise can never land in the same cycle.
    assign period_ok = (cnt_q == DIV_C) && (high_q == HALF_C);
    assign good_inc  = good_q + 1'b1;

    // Interval counter, lock/fault state machine and measurement capture
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        good_d   = good_q;
        err_d    = 1'b0;

        if (state_q == IDLE)  cnt_d = '0;
        else if (rise)        cnt_d = CNT_W'(1);
        else if (&cnt_q)      cnt_d = cnt_q;
        else                  cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                good_d = '0;
                if (en) state_d = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                // first rise only restarts the count; no interval to judge yet
                if (!en)       state_d = IDLE;
                else if (rise) state_d = MEASURE;
            end
            MEASURE, LOCKED: begin
                if (!en) begin
                    state_d = IDLE;
                    good_d  = '0;
                end else begin
                    if (fall) high_d = cnt_q;
                    if (rise) begin
                        period_d = cnt_q;
                        if (!period_ok) begin
                            err_d   = 1'b1;
                            good_d  = '0;
                            state_d = MEASURE;
                        end else if (state_q == MEASURE) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_C) state_d = LOCKED;
                        end
                    end else if (cnt_q == TMO_C) begin
                        // stuck clock: WAIT_EDGE has no timeout, so it fires once
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = WAIT_EDGE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fault counter: counts visible err pulses; a coincident clear loses to the error
    always_comb begin
        errc_d = errc_q;
        if (err_q)          errc_d = clear_err ? ERR_W'(1) : ((&errc_q) ? errc_q : errc_q + 1'b1);
        else if (clear_err) errc_d = '0;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            high_q       <= '0;
            good_q       <= '0;
            err_q        <= 1'b0;
            errc_q       <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            prev_q       <= sync;
            rise_pulse_q <= rise;
            fall_pulse_q <= fall;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            good_q       <= good_d;
            err_q        <= err_d;
            errc_q       <= errc_d;
        end
    end

    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
    assign period     = period_q;
    assign high_time  = high_q;
    // dropping en clears lock in the same cycle, ahead of the state change
    assign locked     = (state_q == LOCKED) & en;
    assign err        = err_q;
    assign err_count  = errc_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: event-level reference model plus directed phases.
module tb_clk_div_monitor;
    localparam int DIV = 4, SS = 2, LOCK = 4, CMAX = 255, EMAX = 255;
    localparam int MS_IDLE = 0, MS_WAIT = 1, MS_MEAS = 2, MS_LOCK = 3;

    logic clk, rst, en, clear_err, div_clk_i;
    logic rise_pulse, fall_pulse, locked, err;
    logic [7:0] period, high_time, err_count;

    clk_div_monitor #(.DIV_RATIO(DIV), .CNT_W(8), .SYNC_STAGES(SS), .LOCK_COUNT(LOCK), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .clear_err(clear_err), .div_clk_i(div_clk_i),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
        .high_time(high_time), .locked(locked), .err(err), .err_count(err_count));

    int nvec = 0, nmis = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Waveform generator: hi_len=0 holds the input low
    int hi_len = 0, lo_len = 2, stretch_req = 0, stretch_done = 0, gh, gl;
    initial begin
        div_clk_i = 1'b0;
        forever begin
            if (hi_len == 0) begin
                div_clk_i = 1'b0;
                @(negedge clk);
            end else begin
                gh = hi_len; gl = lo_len;
                if (stretch_req != stretch_done) begin gh = gh + 2; stretch_done++; end
                div_clk_i = 1'b1; repeat (gh) @(negedge clk);
                div_clk_i = 1'b0; repeat (gl) @(negedge clk);
            end
        end
    end

    // Reference model: works in edge indices; an edge on the input appears as
    // a strobe SS clocks after it is first sampled, intervals are index differences
    logic hist [0:SS];
    int   k, last_rise, good, mst, d;
    bit   rp, fp, m_rise, m_fall, m_err;
    int   m_per, m_high, m_errc;
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
                k = 0; last_rise = 0; good = 0; mst = MS_IDLE;
                m_rise = 0; m_fall = 0; m_err = 0; m_per = 0; m_high = 0; m_errc = 0;
            end else begin
                rp = hist[SS-1] && !hist[SS];
                fp = !hist[SS-1] && hist[SS];
                for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = div_clk_i;
                k++;
                if (m_err) m_errc = clear_err ? 1 : (m_errc == EMAX ? EMAX : m_errc + 1);
                else if (clear_err) m_errc = 0;
                m_err = 0; m_rise = rp; m_fall = fp;
                d = k - last_rise; if (d > CMAX) d = CMAX;
                if (mst == MS_IDLE) begin
                    good = 0;
                    if (en) mst = MS_WAIT;
                end else if (!en) begin
                    mst = MS_IDLE; good = 0;
                end else begin
                    if (fp && mst != MS_WAIT) m_high = d;
                    if (rp) begin
                        if (mst == MS_WAIT) mst = MS_MEAS;
                        else begin
                            m_per = d;
                            if (d == DIV && m_high == DIV / 2) begin
                                if (mst == MS_MEAS) begin good++; if (good == LOCK) mst = MS_LOCK; end
                            end else begin
                                m_err = 1; good = 0; mst = MS_MEAS;
                            end
                        end
                        last_rise = k;
                    end else if (mst != MS_WAIT && k - last_rise == 2 * DIV) begin
                        m_err = 1; good = 0; mst = MS_WAIT;
                    end
                end
            end
        end
    end

    // Per-cycle compare plus event bookkeeping for the directed checks
    int  cyc = 0, rise_seen = 0, err_seen = 0, lock_at_rise = 0, err_rise = 0;
    int  err_gap = 0, err_period = 0, last_rise_cyc = 0;
    bit  locked_prev = 0, e_lock;
    initial begin
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                rise_seen = 0; err_seen = 0; lock_at_rise = 0; locked_prev = 0;
            end else begin
                cyc++;
                e_lock = (mst == MS_LOCK) && en;
                nvec++;
                if (rise_pulse !== m_rise || fall_pulse !== m_fall || period !== 8'(m_per) ||
                    high_time !== 8'(m_high) || locked !== e_lock || err !== m_err ||
                    err_count !== 8'(m_errc)) begin
                    nmis++;
                    $display("FAIL cycle %0d (got/exp): rise %b/%b fall %b/%b period %0d/%0d high %0d/%0d locked %b/%b err %b/%b err_count %0d/%0d",
                             cyc, rise_pulse, m_rise, fall_pulse, m_fall, period, m_per, high_time, m_high,
                             locked, e_lock, err, m_err, err_count, m_errc);
                end
                if (rise_pulse) begin rise_seen++; last_rise_cyc = cyc; end
                if (err) begin err_seen++; err_rise = rise_seen; err_gap = cyc - last_rise_cyc; err_period = period; end
                if (locked && !locked_prev) lock_at_rise = rise_seen;
                locked_prev = locked;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int e0;
    initial begin
        rst = 1'b1; en = 1'b0; clear_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rise", rise_pulse, 0); chk("rst_fall", fall_pulse, 0);
        chk("rst_period", period, 0);   chk("rst_high", high_time, 0);
        chk("rst_locked", locked, 0);   chk("rst_err", err, 0);
        chk("rst_errc", err_count, 0);
        rst = 1'b0; en = 1'b1; hi_len = 2; lo_len = 2;

        // ideal divider locks on the 5th rise
        for (int i = 0; i < 80 && !locked; i++) @(negedge clk);
        repeat (8) @(negedge clk); #2;
        chk("ideal_locked", locked, 1);
        chk("ideal_lock_rise", lock_at_rise, 5);
        chk("ideal_period", period, 4);
        chk("ideal_high", high_time, 2);
        chk("ideal_no_err", err_seen, 0);
        chk("model_period", m_per, 4);
        chk("model_high", m_high, 2);

        // one stretched high phase: single error, then relock after 4 good periods
        stretch_req++;
        for (int i = 0; i < 30 && !err; i++) @(negedge clk);
        repeat (13) @(negedge clk); #2;
        chk("stretch_err_period", err_period, 6);
        chk("stretch_errc", err_count, 1);
        chk("stretch_unlocked", locked, 0);
        for (int i = 0; i < 30 && !locked; i++) @(negedge clk);
        #2;
        chk("stretch_relock", locked, 1);
        chk("stretch_relock_rises", lock_at_rise - err_rise, 4);

        // stuck low: one timeout error 8 cycles after the last rise, no repeats
        hi_len = 0;
        for (int i = 0; i < 40 && !err; i++) @(negedge clk);
        repeat (30) @(negedge clk); #2;
        chk("stuck_gap", err_gap, 8);
        chk("stuck_errs", err_seen, 2);
        chk("stuck_errc", err_count, 2);
        chk("stuck_unlocked", locked, 0);

        // duty fault 3/1; clear coinciding with an error leaves 1
        hi_len = 3; lo_len = 1;
        for (int i = 0; i < 400 && err_count != 5; i++) @(negedge clk);
        chk("duty_errc5", err_count, 5);
        chk("duty_unlocked", locked, 0);
        for (int i = 0; i < 20 && !err; i++) @(negedge clk);
        chk("duty_err_pulse", err, 1);
        clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0; #1;
        chk("clear_vs_err", err_count, 1);

        // saturation at 255
        for (int i = 0; i < 1500 && err_count != 8'd255; i++) @(negedge clk);
        e0 = err_seen;
        repeat (20) @(negedge clk); #2;
        chk("errc_sat", err_count, 255);
        chk("err_still_pulsing", err_seen > e0, 1);

        // plain clear once quiet
        hi_len = 0;
        repeat (30) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0; #1;
        chk("clear_plain", err_count, 0);

        // enable drop: lock clears at once, measurements retained
        hi_len = 2; lo_len = 2;
        for (int i = 0; i < 100 && !locked; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        en = 1'b0; #1;
        chk("en_off_locked", locked, 0);
        chk("en_off_period", period, 4);
        repeat (6) @(negedge clk);
        chk("en_off_high", high_time, 2);
        en = 1'b1;
        for (int i = 0; i < 100 && !locked; i++) @(negedge clk);
        chk("en_relock", locked, 1);

        // asynchronous reset mid-lock
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_locked", locked, 0);  chk("arst_period", period, 0);
        chk("arst_high", high_time, 0); chk("arst_rise", rise_pulse, 0);
        chk("arst_fall", fall_pulse, 0); chk("arst_err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100 && !locked; i++) @(negedge clk);
        #2;
        chk("arst_relock", locked, 1);
        chk("arst_lock_rise", lock_at_rise, 5);

        repeat (4) @(negedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
